// File: rtl/sel_strobe_pkg.sv
// Shared types and constants for the select/strobe initiator.
package sel_strobe_pkg;

  localparam int unsigned SEL_IDX_W = 3;
  localparam int unsigned SEL_W     = 7;
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned CODE_W    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [CODE_W-1:0] RSP_HI   = 2'b00;
  localparam logic [CODE_W-1:0] RSP_LO   = 2'b01;
  localparam logic [CODE_W-1:0] RSP_BOTH = 2'b10;
  localparam logic [CODE_W-1:0] RSP_TMO  = 2'b11;

endpackage

// File: rtl/sel_strobe_initiator.sv
// Drives a one-hot select and mode, strobes en_o until the responder acks or
// the timeout expires, then holds the result until the consumer takes it.
module sel_strobe_initiator
  import sel_strobe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [SEL_IDX_W-1:0] cmd_sel,
  input  logic [MODE_W-1:0]    cmd_mode,
  output logic [SEL_W-1:0]     sel_o,
  output logic [MODE_W-1:0]    mode_o,
  output logic                 en_o,
  input  logic                 ack_hi,
  input  logic                 ack_lo,
  output logic                 rsp_valid,
  output logic [CODE_W-1:0]    rsp_code,
  input  logic                 rsp_ready,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [SEL_W-1:0]    sel_dec, sel_nx;
  logic [MODE_W-1:0]   mode_nx;
  logic                en_nx, rsp_valid_nx, cmd_ready_nx, busy_nx;
  logic [CODE_W-1:0]   rsp_code_nx;
  logic                any_ack;

  assign any_ack = ack_hi | ack_lo;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_valid && cmd_ready) state_nx = SETUP;
      SETUP:   state_nx = STROBE;
      STROBE:  if (any_ack || cnt == CNT_LAST) state_nx = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // 3-to-7 select decode; code 0 selects nothing
  always_comb begin
    sel_dec = '0;
    if (cmd_sel != '0) sel_dec = SEL_W'(1) << (cmd_sel - SEL_IDX_W'(1));
  end

  // Next values for the registered outputs and the timeout counter
  always_comb begin
    sel_nx       = sel_o;
    mode_nx      = mode_o;
    en_nx        = en_o;
    rsp_valid_nx = rsp_valid;
    rsp_code_nx  = rsp_code;
    cnt_nx       = cnt;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          sel_nx  = sel_dec;
          mode_nx = cmd_mode;
        end
      end
      SETUP: begin
        en_nx  = 1'b1;
        cnt_nx = '0;
      end
      STROBE: begin
        cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        if (any_ack || cnt == CNT_LAST) begin
          // An ack in the final cycle takes priority over the timeout
          if (ack_hi && ack_lo) rsp_code_nx = RSP_BOTH;
          else if (ack_hi)      rsp_code_nx = RSP_HI;
          else if (ack_lo)      rsp_code_nx = RSP_LO;
          else                  rsp_code_nx = RSP_TMO;
          rsp_valid_nx = 1'b1;
          en_nx        = 1'b0;
          sel_nx       = '0;
          mode_nx      = '0;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) rsp_valid_nx = 1'b0;
      end
      default: begin
        en_nx        = 1'b0;
        rsp_valid_nx = 1'b0;
      end
    endcase
    cmd_ready_nx = (state_nx == IDLE);
    busy_nx      = (state_nx != IDLE);
  end

  // Output and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sel_o     <= '0;
      mode_o    <= '0;
      en_o      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_code  <= RSP_HI;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      sel_o     <= sel_nx;
      mode_o    <= mode_nx;
      en_o      <= en_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_code  <= rsp_code_nx;
      cmd_ready <= cmd_ready_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_sel_strobe_initiator.sv
// Directed self-checking bench for sel_strobe_initiator (TIMEOUT=4).
module tb_sel_strobe_initiator;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_sel;
  logic [1:0] cmd_mode;
  logic [6:0] sel_o;
  logic [1:0] mode_o;
  logic       en_o;
  logic       ack_hi;
  logic       ack_lo;
  logic       rsp_valid;
  logic [1:0] rsp_code;
  logic       rsp_ready;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  wire [14:0] obs = {cmd_ready, busy, sel_o, mode_o, en_o, rsp_valid, rsp_code};
  localparam logic [14:0] RESET_OBS = {1'b1, 1'b0, 7'd0, 2'd0, 1'b0, 1'b0, 2'd0};

  sel_strobe_initiator #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_mode(cmd_mode),
    .sel_o(sel_o), .mode_o(mode_o), .en_o(en_o),
    .ack_hi(ack_hi), .ack_lo(ack_lo),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a command for one cycle; returns in SETUP
  task automatic issue(input logic [2:0] s, input logic [1:0] m);
    cmd_valid = 1'b1;
    cmd_sel   = s;
    cmd_mode  = m;
    tick();
    cmd_valid = 1'b0;
  endtask

  // From SETUP, count en_o-high cycles until en_o drops (bounded)
  task automatic count_strobe(output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (en_o) n++;
      else break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compared++;
    if (obs !== RESET_OBS) begin
      mismatched++;
      $display("FAIL reset_state: got %b want %b", obs, RESET_OBS);
    end
  endtask

  task automatic test_ack_hi();
    issue(3'd3, 2'b10);
    compared++;
    if ({sel_o, mode_o, en_o, cmd_ready, busy} !== {7'b0000100, 2'b10, 1'b0, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL ack_hi_setup: sel=%b mode=%b en=%b rdy=%b busy=%b", sel_o, mode_o, en_o, cmd_ready, busy);
    end
    tick();
    compared++;
    if ({sel_o, mode_o, en_o} !== {7'b0000100, 2'b10, 1'b1}) begin
      mismatched++;
      $display("FAIL ack_hi_strobe1: sel=%b mode=%b en=%b want 0000100 10 1", sel_o, mode_o, en_o);
    end
    tick();
    ack_hi = 1'b1;
    compared++;
    if ({sel_o, en_o, rsp_valid} !== {7'b0000100, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL ack_hi_strobe2: sel=%b en=%b rsp_valid=%b want 0000100 1 0", sel_o, en_o, rsp_valid);
    end
    tick();
    ack_hi = 1'b0;
    compared++;
    if ({rsp_valid, rsp_code, en_o, sel_o, mode_o} !== {1'b1, 2'b00, 1'b0, 7'd0, 2'd0}) begin
      mismatched++;
      $display("FAIL ack_hi_resp: valid=%b code=%b en=%b sel=%b mode=%b want 1 00 0 0 0", rsp_valid, rsp_code, en_o, sel_o, mode_o);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    compared++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
      mismatched++;
      $display("FAIL ack_hi_return: valid=%b rdy=%b busy=%b want 0 1 0", rsp_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_both();
    issue(3'd7, 2'b01);
    compared++;
    if ({sel_o, mode_o, en_o} !== {7'b1000000, 2'b01, 1'b0}) begin
      mismatched++;
      $display("FAIL both_setup: sel=%b mode=%b en=%b want 1000000 01 0", sel_o, mode_o, en_o);
    end
    tick();
    ack_hi = 1'b1;
    ack_lo = 1'b1;
    compared++;
    if ({sel_o, en_o} !== {7'b1000000, 1'b1}) begin
      mismatched++;
      $display("FAIL both_strobe: sel=%b en=%b want 1000000 1", sel_o, en_o);
    end
    tick();
    ack_hi = 1'b0;
    ack_lo = 1'b0;
    compared++;
    if ({rsp_valid, rsp_code} !== 3'b110) begin
      mismatched++;
      $display("FAIL both_code: valid=%b code=%b want 1 10", rsp_valid, rsp_code);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    issue(3'd1, 2'b00);
    count_strobe(n);
    compared++;
    if (n != 4) begin
      mismatched++;
      $display("FAIL timeout_en_cycles: got %0d want 4", n);
    end
    compared++;
    if ({rsp_valid, rsp_code, sel_o} !== {1'b1, 2'b11, 7'd0}) begin
      mismatched++;
      $display("FAIL timeout_code: valid=%b code=%b sel=%b want 1 11 0", rsp_valid, rsp_code, sel_o);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_ack_in_last_cycle();
    issue(3'd2, 2'b11);
    for (int i = 0; i < 4; i++) tick();
    ack_lo = 1'b1;
    tick();
    ack_lo = 1'b0;
    compared++;
    if ({rsp_valid, rsp_code} !== 3'b101) begin
      mismatched++;
      $display("FAIL ack_beats_timeout: valid=%b code=%b want 1 01", rsp_valid, rsp_code);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_null_sel_stall();
    issue(3'd0, 2'b11);
    compared++;
    if ({sel_o, mode_o, busy} !== {7'd0, 2'b11, 1'b1}) begin
      mismatched++;
      $display("FAIL null_sel_setup: sel=%b mode=%b busy=%b want 0 11 1", sel_o, mode_o, busy);
    end
    tick();
    ack_lo = 1'b1;
    tick();
    ack_lo = 1'b0;
    cmd_valid = 1'b1;
    cmd_sel   = 3'd5;
    for (int i = 0; i < 5; i++) begin
      compared++;
      if ({rsp_valid, rsp_code, cmd_ready, busy} !== {1'b1, 2'b01, 1'b0, 1'b1}) begin
        mismatched++;
        $display("FAIL stall_hold[%0d]: valid=%b code=%b rdy=%b busy=%b want 1 01 0 1", i, rsp_valid, rsp_code, cmd_ready, busy);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    compared++;
    if ({rsp_valid, cmd_ready, busy, sel_o} !== {1'b0, 1'b1, 1'b0, 7'd0}) begin
      mismatched++;
      $display("FAIL no_same_cycle_accept: valid=%b rdy=%b busy=%b sel=%b want 0 1 0 0", rsp_valid, cmd_ready, busy, sel_o);
    end
  endtask

  task automatic test_abort();
    issue(3'd4, 2'b10);
    tick();
    tick();
    rst    = 1'b1;
    ack_hi = 1'b1;
    tick();
    rst    = 1'b0;
    ack_hi = 1'b0;
    compared++;
    if (obs !== RESET_OBS) begin
      mismatched++;
      $display("FAIL abort_reset: got %b want %b", obs, RESET_OBS);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if ({rsp_valid, busy} !== 2'b00) begin
        mismatched++;
        $display("FAIL abort_quiet[%0d]: valid=%b busy=%b want 0 0", i, rsp_valid, busy);
      end
    end
  endtask

  task automatic test_setup_ack();
    int n;
    issue(3'd6, 2'b01);
    ack_lo = 1'b1;
    tick();
    ack_lo = 1'b0;
    n = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (en_o) n++;
      else break;
    end
    compared++;
    if ({n[3:0], rsp_valid, rsp_code} !== {4'd4, 1'b1, 2'b11}) begin
      mismatched++;
      $display("FAIL setup_ack_ignored: en_cycles=%0d valid=%b code=%b want 4 1 11", n, rsp_valid, rsp_code);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_sel = '0; cmd_mode = '0;
    ack_hi = 1'b0; ack_lo = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_ack_hi();
    test_both();
    test_timeout();
    test_ack_in_last_cycle();
    test_null_sel_stall();
    test_abort();
    test_setup_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
